nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
//
// PURPOSE
//   Multi-cycle controller that adds or subtracts two wide operands using a single
//   shared 4-bit ripple adder (adder1bit-based adder4bit), one nibble per clock, LSB first.
//   It sits between an operand producer (valid/ready) and a result consumer (valid/ready).
//   It handles operand capture, nibble sequencing, carry chaining, result assembly and flags.
//
// PARAMETERS
//   NIBBLES  4  operand width in nibbles (W = 4*NIBBLES bits); legal range 1..16
//
// PORTS
//   clk        in   1   clock; all state changes on rising edge
//   rst        in   1   reset, asynchronous, active-high
//   in_valid   in   1   operand set a/b/cin/op is valid
//   in_ready   out  1   controller can accept operands
//   a          in   W   operand A
//   b          in   W   operand B
//   cin        in   1   carry-in, used only when op=0
//   op         in   1   0 = add (a+b+cin); 1 = subtract (a-b; cin ignored)
//   out_valid  out  1   result/flags valid, held until taken
//   out_ready  in   1   consumer takes result
//   sum        out  W   result
//   cout       out  1   carry out of MSB nibble (subtract: 1 = no borrow)
//   ovf        out  1   two's-complement signed overflow
//   busy       out  1   high in RUN or DONE
//
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; sum=0, cout=0, ovf=0, out_valid=0;
//     nibble index=0; operand shift registers=0. in_ready=1 after reset is released.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE: in_ready=1. On in_valid:
//       capture a, b_eff = op ? ~b : b, and carry = op ? 1 : cin.
//       Also capture a[W-1] and b_eff[W-1]. Set idx=0, go to RUN.
//     RUN: in_ready=0. Each cycle feed nibble idx of a/b_eff and the carry reg to adder4bit.
//       Shift the 4-bit result into sum from the top (sum >> 4, new nibble in [W-1:W-4]).
//       Load carry with adder cout, then idx++. When idx==NIBBLES-1, also go to DONE.
//     DONE: out_valid=1. cout = final carry. ovf = (a_msb==b_eff_msb) && (sum[W-1]!=a_msb).
//       On out_ready, go to IDLE and clear out_valid; sum/cout/ovf keep their values.
//   - Latency: accept edge E0. Nibble i is written at edge E0+1+i.
//     out_valid rises at edge E0+NIBBLES. Minimum issue interval is NIBBLES+2 cycles.
//   - in_ready = (state==IDLE) only. There is no same-cycle bypass DONE->accept.
//   - in_valid outside IDLE is ignored. The held operands are never overwritten mid-op.
//   - While out_valid=1 and out_ready=0: sum, cout, ovf stay stable (no change).
//   - NIBBLES=1: RUN lasts exactly one cycle.
//   - Index counter width is clog2(NIBBLES)+1. It never wraps: exit is on NIBBLES-1.
//   - Reset mid-RUN or mid-DONE aborts the operation. Nothing partial is ever presented.
//
// STRUCTURE
//   - Shared package/header nibble_add_pkg: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1,
//     ST_DONE=2'd2), OP_ADD=1'b0, OP_SUB=1'b1, NIBBLE_W=4.
//   - One sub-module instance: the existing 4-bit adder (adder4bit), used as-is.
//     It is the only arithmetic in the block. All other logic is FSM, counter,
//     shift registers and flag logic.
//
// TESTING (NIBBLES=4)
//   1. add a=0x1234, b=0x0FFF, cin=0 -> sum=0x2233, cout=0, ovf=0.
//      out_valid rises exactly 4 cycles after the accept edge.
//   2. add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//      add a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
//   3. sub a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
//      sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//   4. Backpressure: out_ready=0 for 3 cycles in DONE -> sum/flags stable, in_ready=0.
//      A concurrent in_valid with a=0xAAAA is ignored. After out_ready, next accept
//      occurs no earlier than the cycle after return to IDLE.
//   5. rst pulsed 2 cycles into RUN -> out_valid, sum, cout, ovf = 0 immediately.
//      in_ready=1 after release. A fresh op then gives a correct result.
//   6. Back-to-back random add/sub (1000 ops) with random in_valid/out_ready
//      -> every result matches the reference model ({cout,sum} and ovf).

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared encodings for the nibble-serial add/subtract controller.
// States, op codes and the nibble width of the shared adder.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder1bit.sv
// One-bit full adder, the building block of the shared nibble adder.
module adder1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder4bit.sv
// Four-bit ripple-carry adder built from adder1bit cells.
module adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;
    assign cout = c[4];

    for (genvar i = 0; i < 4; i++) begin : g_bit
        adder1bit u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .cout(c[i+1])
        );
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract done one nibble per clock through a single 4-bit adder,
// LSB first, with valid/ready handshakes on operands and result.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    input  logic                      op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      busy
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES) + 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e state_q, state_d;

    logic [W-1:0]        a_q, b_q;
    logic [W-1:0]        a_shift, b_shift, sum_shift;
    logic [W-1:0]        b_eff;
    logic [IW-1:0]       idx_q;
    logic                carry_q, a_msb_q, b_msb_q;
    logic                last;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    adder4bit u_add (
        .a   (a_q[NIBBLE_W-1:0]),
        .b   (b_q[NIBBLE_W-1:0]),
        .cin (carry_q),
        .sum (nib_sum),
        .cout(nib_cout)
    );

    assign b_eff     = (op == OP_SUB) ? ~b : b;
    assign last      = (idx_q == LAST);
    assign a_shift   = W'({{NIBBLE_W{1'b0}}, a_q} >> NIBBLE_W);
    assign b_shift   = W'({{NIBBLE_W{1'b0}}, b_q} >> NIBBLE_W);
    // New nibble enters at the top so the LSB nibble ends up at the bottom.
    assign sum_shift = W'({nib_sum, sum} >> NIBBLE_W);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= (op == OP_SUB) ? 1'b1 : cin;
                        a_msb_q <= a[W-1];
                        b_msb_q <= b_eff[W-1];
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_shift;
                    b_q     <= b_shift;
                    sum     <= sum_shift;
                    carry_q <= nib_cout;
                    idx_q   <= idx_q + 1'b1;
                    // Flags latch together with the final nibble.
                    if (last) begin
                        cout <= nib_cout;
                        ovf  <= (a_msb_q == b_msb_q) &&
                                (nib_sum[NIBBLE_W-1] != a_msb_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with NIBBLES=4.
module tb_nibble_serial_add_ctrl;

    localparam int NIB = 4;
    localparam int W   = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, mb,
                                   input logic mc, mo);
        exp_t       e;
        logic [W:0] r;
        if (mo) begin
            r     = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
            e.ovf = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        end else begin
            r     = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
            e.ovf = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
        end
        e.sum  = r[W-1:0];
        e.cout = r[W];
        return e;
    endfunction

    task automatic send(input logic [W-1:0] ta, tb, input logic tc, to,
                        input exp_t e);
        int n;
        sb.push_back(e);
        @(negedge clk);
        a = ta; b = tb; cin = tc; op = to; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL out_timeout out_valid=%0b required=1", out_valid);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b busy=%0b sum=%h c=%0b o=%0b required all 0",
                     out_valid, busy, sum, cout, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b required 1", in_ready);
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] tb[5] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         to[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t         te[5] = '{{16'h2233, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0},
                                {16'h8000, 1'b0, 1'b1}, {16'hFFFE, 1'b0, 1'b0},
                                {16'h7FFF, 1'b1, 1'b1}};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 5; i++) begin
            send(ta[i], tb[i], tc[i], to[i], te[i]);
            wait_out(cyc);
            if (i == 0) begin
                checks++;
                if (cyc != NIB) begin
                    errors++;
                    $display("FAIL latency got %0d required %0d", cyc, NIB);
                end
            end
            e = sb.pop_front();
            checks++;
            if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL arith_%0d got sum=%h c=%0b o=%0b required sum=%h c=%0b o=%0b",
                         i, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            take();
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL arith_take_%0d got v=%0b rdy=%0b required v=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});
        wait_out(cyc);
        e = sb.pop_front();
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0; op = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({sum, cout, ovf, in_ready, out_valid} !== {e.sum, e.cout, e.ovf, 2'b01}) begin
                errors++;
                $display("FAIL hold_%0d got sum=%h c=%0b o=%0b rdy=%0b v=%0b required sum=%h c=%0b o=%0b rdy=0 v=1",
                         i, sum, cout, ovf, in_ready, out_valid, e.sum, e.cout, e.ovf);
            end
        end
        take();
        checks++;
        if ({busy, in_ready, sum} !== {2'b01, e.sum}) begin
            errors++;
            $display("FAIL no_bypass got busy=%0b rdy=%0b sum=%h required busy=0 rdy=1 sum=%h",
                     busy, in_ready, sum, e.sum);
        end
        sb.push_back('{16'hFFFF, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL after_hold got sum=%h c=%0b o=%0b required sum=%h c=%0b o=%0b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        take();
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   cyc;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, '{16'h3333, 1'b0, 1'b0});
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, sum, cout, ovf} !== '0) begin
            errors++;
            $display("FAIL abort got v=%0b busy=%0b sum=%h c=%0b o=%0b required all 0",
                     out_valid, busy, sum, cout, ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %0b required 1", in_ready);
        end
        send(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL post_abort got sum=%h c=%0b o=%0b required sum=%h c=%0b o=%0b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        take();
    endtask

    task automatic test_back_to_back();
        int n_ops = 1000;
        int got = 0;
        int cyc = 0;
        fork
            begin
                logic [W-1:0] ra, rb;
                logic         rc, ro;
                int           n;
                for (int i = 0; i < n_ops; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    ra = 16'($urandom); rb = 16'($urandom);
                    rc = 1'($urandom);  ro = 1'($urandom);
                    a = ra; b = rb; cin = rc; op = ro; in_valid = 1'b1;
                    n = 0;
                    while (!in_ready && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!in_ready) begin
                        checks++; errors++;
                        $display("FAIL b2b_accept_timeout op=%0d", i);
                        break;
                    end
                    sb.push_back(model(ra, rb, rc, ro));
                    @(posedge clk);
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            begin
                exp_t e;
                while (got < n_ops && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_extra got sum=%h required no result", sum);
                        end else begin
                            e = sb.pop_front();
                            if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                                errors++;
                                $display("FAIL b2b_%0d got sum=%h c=%0b o=%0b required sum=%h c=%0b o=%0b",
                                         got, sum, cout, ovf, e.sum, e.cout, e.ovf);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        checks++;
        if (got != n_ops) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", got, n_ops);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
